// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and a
// post-reset sequential clear engine. Optional macro: REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 2,
  parameter int NWR  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  output logic                 ready,
  output logic [XLEN-1:0]      reg_a0
);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW-1:0]   wa [NWR];
  logic [AW-1:0]   ra [NRD];
  logic            run;
  logic            upd_en;

  // Address 0 is hardwired zero; addresses beyond NREG do not exist.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < 32'(NREG));
  endfunction

  assign run    = (state_q == ST_RUN);
  assign upd_en = run && !rst;
  assign ready  = run;

  always_comb begin
    for (int unsigned p = 0; p < NWR; p++) wa[p] = wr_addr[p*AW +: AW];
    for (int unsigned i = 0; i < NRD; i++) ra[i] = rd_addr[i*AW +: AW];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      if (cnt_q == AW'(NREG - 1)) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + AW'(1);
      end
    end
  end

  // Ascending port loop: a later (higher-index) port overrides earlier ones.
  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) regs_d[r] = regs_q[r];
    if (!rst) begin
      if (!run) begin
        for (int unsigned r = 0; r < NREG; r++)
          if (cnt_q == AW'(r)) regs_d[r] = '0;
      end else begin
        for (int unsigned p = 0; p < NWR; p++)
          if (wr_en[p] && in_range(wa[p]))
            for (int unsigned r = 0; r < NREG; r++)
              if (wa[p] == AW'(r)) regs_d[r] = wr_data[p*XLEN +: XLEN];
      end
    end
    regs_d[0] = '0;
  end

  // Retiring writes clear first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (upd_en) begin
      for (int unsigned p = 0; p < NWR; p++)
        if (wr_en[p] && in_range(wa[p]))
          for (int unsigned r = 0; r < NREG; r++)
            if (wa[p] == AW'(r)) busy_d[r] = 1'b0;
      if (sb_set_en && in_range(sb_set_addr))
        for (int unsigned r = 0; r < NREG; r++)
          if (sb_set_addr == AW'(r)) busy_d[r] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (run && in_range(ra[i])) begin
        for (int unsigned r = 0; r < NREG; r++)
          if (ra[i] == AW'(r)) begin
            rd_data[i*XLEN +: XLEN] = regs_q[r];
            rd_busy[i]              = busy_q[r];
          end
`ifdef REGFILE_BYPASS_EN
        for (int unsigned p = 0; p < NWR; p++)
          if (wr_en[p] && (wa[p] == ra[i]))
            rd_data[i*XLEN +: XLEN] = wr_data[p*XLEN +: XLEN];
`endif
      end
    end
  end

  generate
    if (NREG > 10) begin : g_a0
      assign reg_a0 = run ? regs_q[10] : '0;
    end else begin : g_no_a0
      assign reg_a0 = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Array is not reset; the clear engine zeroes it after reset releases.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
  end

endmodule
